// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, control states and the default operand width.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  // Only meaningful for the four arithmetic ops: bit 0 clear means signed.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op[0] == 1'b0);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative datapath: one shift-add (multiply) or one restoring
// shift-subtract (divide) step per enabled cycle on a 2*WIDTH accumulator.
// Multiply: acc = {product_hi, product_lo}. Divide: acc = {remainder, quotient}.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             last,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   op_b;
  logic [CW-1:0]      count;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_part;
  logic [WIDTH-1:0]   div_rem;

  // Next accumulator value for a single multiply or divide step.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_b} : '0);
    div_part = acc[2*WIDTH-1:WIDTH-1];
    // Only used when div_part >= op_b, where the difference fits in WIDTH bits.
    div_rem  = div_part[WIDTH-1:0] - op_b;
    acc_next = {mul_sum, acc[WIDTH-1:1]};
    if (div_mode) begin
      if (div_part >= {1'b0, op_b}) begin
        acc_next = {div_rem, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {div_part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Accumulator, divisor/multiplicand and step counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc   <= '0;
      op_b  <= '0;
      count <= '0;
    end else if (load) begin
      acc   <= {{WIDTH{1'b0}}, operand_a};
      op_b  <= operand_b;
      count <= '0;
    end else if (step) begin
      acc   <= acc_next;
      count <= count + 1'b1;
    end
  end

  assign last   = (count == CW'(WIDTH - 1));
  assign acc_hi = acc[2*WIDTH-1:WIDTH];
  assign acc_lo = acc[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// Handshake: i_start is sampled only while o_busy=0; an accepted MULT/DIV
// holds o_busy for WIDTH+1 cycles and then pulses o_done for one cycle,
// in which a new i_start may already be accepted. MTHI/MTLO complete at
// the accept edge with no busy and no done.
// Optional build macro MULDIV_DIV0_FLAG_EN adds o_div_by_zero, which
// pulses with o_done when a divide had a zero divisor.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
`ifdef MULDIV_DIV0_FLAG_EN
  ,
  output logic             o_div_by_zero
`endif
);

  state_t state;
  state_t state_next;

  logic             op_mul;
  logic             op_div;
  logic             op_signed;
  logic             load;
  logic             step;
  logic             core_last;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  logic             is_div_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             div0_r;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Request decode and operand magnitudes for the unsigned core.
  always_comb begin
    op_mul    = (i_op == OP_MULT) || (i_op == OP_MULTU);
    op_div    = (i_op == OP_DIV)  || (i_op == OP_DIVU);
    op_signed = op_is_signed(i_op);
    abs_a     = (op_signed && i_operand_a[WIDTH-1]) ? -i_operand_a : i_operand_a;
    abs_b     = (op_signed && i_operand_b[WIDTH-1]) ? -i_operand_b : i_operand_b;
  end

  // Control FSM: next state and core strobes.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start && op_mul) begin
          load       = 1'b1;
          state_next = ST_MUL;
        end else if (i_start && op_div) begin
          load       = 1'b1;
          state_next = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: begin
        step = 1'b1;
        if (core_last) begin
          state_next = ST_FIX;
        end
      end
      ST_FIX: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Sign correction of the unsigned core result; divide by zero forces
  // an all-ones quotient while the remainder restores the dividend.
  always_comb begin
    prod_fix = {core_hi, core_lo};
    if (neg_q_r) begin
      prod_fix = -prod_fix;
    end
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (is_div_r) begin
      fix_hi = neg_r_r ? -core_hi : core_hi;
      fix_lo = neg_q_r ? -core_lo : core_lo;
      if (div0_r) begin
        fix_lo = '1;
      end
    end
  end

  muldiv_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .div_mode  (is_div_r),
    .operand_a (abs_a),
    .operand_b (abs_b),
    .last      (core_last),
    .acc_hi    (core_hi),
    .acc_lo    (core_lo)
  );

  // State register, operation flags, HI/LO and the done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      o_done   <= 1'b0;
      o_hi     <= '0;
      o_lo     <= '0;
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      div0_r   <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
      o_div_by_zero <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      o_done <= (state == ST_FIX);
`ifdef MULDIV_DIV0_FLAG_EN
      o_div_by_zero <= (state == ST_FIX) && is_div_r && div0_r;
`endif
      if (load) begin
        is_div_r <= op_div;
        neg_q_r  <= op_signed && (i_operand_a[WIDTH-1] ^ i_operand_b[WIDTH-1]);
        neg_r_r  <= op_signed && i_operand_a[WIDTH-1];
        div0_r   <= op_div && (i_operand_b == '0);
      end
      if (state == ST_FIX) begin
        o_hi <= fix_hi;
        o_lo <= fix_lo;
      end else if (state == ST_IDLE && i_start && i_op == OP_MTHI) begin
        o_hi <= i_operand_a;
      end else if (state == ST_IDLE && i_start && i_op == OP_MTLO) begin
        o_lo <= i_operand_a;
      end
    end
  end

  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed scenarios plus randomized operations,
// results checked by a queue-based scoreboard against a plain-arithmetic model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         i_start;
  logic [2:0]   i_op;
  logic [W-1:0] i_operand_a;
  logic [W-1:0] i_operand_b;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_hi;
  logic [W-1:0] o_lo;
`ifdef MULDIV_DIV0_FLAG_EN
  logic         o_div_by_zero;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [2*W-1:0] exp_q[$];
  logic           exp_dz_q[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_start     (i_start),
    .i_op        (i_op),
    .i_operand_a (i_operand_a),
    .i_operand_b (i_operand_b),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_hi        (o_hi),
    .o_lo        (o_lo)
`ifdef MULDIV_DIV0_FLAG_EN
    ,
    .o_div_by_zero (o_div_by_zero)
`endif
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op == OP_MULT) return sa * sb;
    if (op == OP_MULTU) return ua * ub;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == OP_DIV) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = longint'(ua / ub);
      r = longint'(ua % ub);
    end
    return {r[31:0], q[31:0]};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    logic [63:0] e;
    logic        dz;
    if (!reset && o_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(o_done), 64'd0);
      end else begin
        e  = exp_q.pop_front();
        dz = exp_dz_q.pop_front();
        check("result_hi_lo", {o_hi, o_lo}, e);
`ifdef MULDIV_DIV0_FLAG_EN
        check("div_by_zero_flag", 64'(o_div_by_zero), 64'(dz));
`else
        if (dz) check("div0_lo_all_ones", 64'(o_lo), 64'hFFFF_FFFF);
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; presents a request for one clock edge, then scrambles inputs.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    i_start     = 1'b1;
    i_op        = op;
    i_operand_a = a;
    i_operand_b = b;
    @(posedge clock);
    #1;
    i_start     = 1'b0;
    i_op        = 3'($urandom_range(0, 7));
    i_operand_a = $urandom;
    i_operand_b = $urandom;
  endtask

  // MULT/DIV: push expectation, issue, measure busy length, check hold and done.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit intrude);
    logic [63:0] prev;
    int          busy_cycles;
    prev        = {o_hi, o_lo};
    busy_cycles = 0;
    exp_q.push_back(ref_model(op, a, b));
    exp_dz_q.push_back(op[1] && (b == '0));
    issue(op, a, b);
    @(negedge clock);
    while (o_busy && busy_cycles < 100) begin
      busy_cycles++;
      if (intrude && busy_cycles == 5) begin
        i_start     = 1'b1;
        i_op        = OP_MULT;
        i_operand_a = 32'd2;
        i_operand_b = 32'd3;
      end
      if (busy_cycles == 6) i_start = 1'b0;
      if (busy_cycles == 33) check("hold_hi_lo_while_busy", {o_hi, o_lo}, prev);
      @(negedge clock);
    end
    check("busy_cycles", 64'(busy_cycles), 64'd33);
    check("done_after_busy", 64'(o_done), 64'd1);
  endtask

  // MTHI/MTLO: direct update at the accept edge, never busy or done.
  task automatic mt(input logic [2:0] op, input logic [W-1:0] a);
    logic [63:0] prev;
    logic [63:0] exp;
    prev = {o_hi, o_lo};
    exp  = (op == OP_MTHI) ? {a, prev[31:0]} : {prev[63:32], a};
    issue(op, a, $urandom);
    @(negedge clock);
    check("mt_hi_lo", {o_hi, o_lo}, exp);
    check("mt_busy", 64'(o_busy), 64'd0);
    check("mt_done", 64'(o_done), 64'd0);
  endtask

  // Reserved op: nothing changes.
  task automatic reserved_op(input logic [2:0] op);
    logic [63:0] prev;
    prev = {o_hi, o_lo};
    issue(op, $urandom, $urandom);
    @(negedge clock);
    check("reserved_hi_lo", {o_hi, o_lo}, prev);
    check("reserved_busy", 64'(o_busy), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]   op;
    logic [W-1:0] a, b;
    int           sel;

    reset       = 1'b1;
    i_start     = 1'b0;
    i_op        = 3'd0;
    i_operand_a = '0;
    i_operand_b = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_done", 64'(o_done), 64'd0);
    check("reset_hi_lo", {o_hi, o_lo}, 64'd0);

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);          // back-to-back in done cycle
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(OP_DIVU, 32'd5, 32'd0, 1'b0);
    run_op(OP_DIV, 32'hFFFF_FFF0, 32'd0, 1'b0);
    @(negedge clock);

    mt(OP_MTHI, 32'h1234_5678);
    mt(OP_MTLO, 32'h9ABC_DEF0);
    reserved_op(3'b110);
    reserved_op(3'b111);

    run_op(OP_DIVU, 32'd100, 32'd7, 1'b1);
    @(negedge clock);

    // Reset in the middle of a MULTU: no result expected.
    issue(OP_MULTU, $urandom, $urandom);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midop_reset_busy", 64'(o_busy), 64'd0);
    check("midop_reset_done", 64'(o_done), 64'd0);
    check("midop_reset_hi_lo", {o_hi, o_lo}, 64'd0);
    repeat (40) @(negedge clock);
    run_op(OP_MULTU, 32'd6, 32'd7, 1'b0);

    // Randomized operations with corner-value injection.
    for (int i = 0; i < 24; i++) begin
      op  = 3'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      a   = $urandom;
      b   = $urandom;
      case (sel)
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      run_op(op, a, b, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) mt(($urandom_range(0, 1) == 0) ? OP_MTHI : OP_MTLO, $urandom);
      else if ($urandom_range(0, 1) == 0) @(negedge clock);
    end

    repeat (5) @(negedge clock);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
